// File: rtl/tap_pkg.sv
// Shared types and helpers for the TapTempo button front end.
// Holds the arbiter state encoding, the tick divider computation and
// the width helper for the event channel index.
package tap_pkg;

  typedef enum logic [0:0] {
    s_idle  = 1'b0,
    s_offer = 1'b1
  } arb_state_e;

  // Number of clock cycles per timepulse tick (integer division).
  function automatic int calcDiv(input int clkPerNs, input int pulsePerNs);
    return pulsePerNs / clkPerNs;
  endfunction

  // Width of a channel index; never narrower than one bit.
  function automatic int idWidth(input int nBtn);
    return (nBtn > 1) ? $clog2(nBtn) : 1;
  endfunction

endpackage

// File: rtl/tap_event_arbiter_tick_prescaler.sv
// Timepulse prescaler: tp_o is high for one cycle every DIV cycles.
// The first pulse appears DIV cycles after reset is released.
module tick_prescaler #(
  parameter int DIV = 102
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tp_o
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] pcnt_q, pcnt_d;
  logic          tp_q;

  // Next count value, wrapping after DIV-1.
  always_comb begin
    pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + CW'(1);
  end

  // Counter and registered tick output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
      tp_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tp_q   <= (pcnt_q == LAST);
    end
  end

  assign tp_o = tp_q;

endmodule

// File: rtl/tap_event_arbiter.sv
// TapTempo button front end: shared debouncer tick, rising-edge capture
// into a pending vector, and round-robin arbitration onto a valid/ready
// event stream. Optional per-event tick timestamps are enabled with the
// TAP_TIMESTAMP_EN macro.
module tap_event_arbiter
  import tap_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int CLK_PER_NS   = 40,
  parameter int PULSE_PER_NS = 4096,
  parameter int TS_WIDTH     = 16,
  localparam int ID_W        = idWidth(N_BTN)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                tp_o,
  input  logic [N_BTN-1:0]    btn_i,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [ID_W-1:0]     evt_id_o,
`ifdef TAP_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0] evt_ts_o,
`endif
  output logic [N_BTN-1:0]    pend_o,
  output logic                ovf_o
);

  localparam int DIV = calcDiv(CLK_PER_NS, PULSE_PER_NS);

  if (N_BTN < 2) begin : gBadNBtn
    $error("tap_event_arbiter: N_BTN must be at least 2");
  end
  if (DIV < 2) begin : gBadDiv
    $error("tap_event_arbiter: PULSE_PER_NS/CLK_PER_NS must be at least 2");
  end
  if (TS_WIDTH < 1) begin : gBadTs
    $error("tap_event_arbiter: TS_WIDTH must be at least 1");
  end

  logic             tp;
  logic [N_BTN-1:0] btn_q;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] edgeVec, clrVec;
  logic             ovf_q, ovf_d;
  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
  logic [ID_W-1:0]  evtId_q, evtId_d;
  logic [ID_W-1:0]  grantIdx;
  logic [ID_W:0]    candIdx;
  logic             grantFound;
  logic             grantNow;

  tick_prescaler #(
    .DIV (DIV)
  ) uPrescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tp_o  (tp)
  );

  assign tp_o    = tp;
  assign edgeVec = btn_i & ~btn_q;

  // Find the first pending channel at or above rrPtr, wrapping modulo N_BTN.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      candIdx = {1'b0, rrPtr_q} + (ID_W+1)'(i);
      if (candIdx >= (ID_W+1)'(N_BTN)) begin
        candIdx = candIdx - (ID_W+1)'(N_BTN);
      end
      if (!grantFound && pend_q[candIdx[ID_W-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx[ID_W-1:0];
      end
    end
  end

  assign grantNow = (state_q == s_idle) && grantFound;

  // Pending update: a new edge wins over a same-cycle grant clear.
  always_comb begin
    clrVec = grantNow ? (N_BTN'(1) << grantIdx) : '0;
    pend_d = (pend_q & ~clrVec) | edgeVec;
    ovf_d  = |(edgeVec & pend_q & ~clrVec);
  end

  // Offer FSM: grant from idle, hold the offer until the consumer accepts.
  always_comb begin
    state_d = state_q;
    evtId_d = evtId_q;
    rrPtr_d = rrPtr_q;
    case (state_q)
      s_idle: begin
        if (grantFound) begin
          state_d = s_offer;
          evtId_d = grantIdx;
        end
      end
      s_offer: begin
        if (evt_ready_i) begin
          state_d = s_idle;
          rrPtr_d = (evtId_q == ID_W'(N_BTN - 1)) ? '0 : evtId_q + ID_W'(1);
        end
      end
      default: state_d = s_idle;
    endcase
  end

  // Edge history, pending vector, overflow pulse and arbiter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= s_idle;
      rrPtr_q <= '0;
      evtId_q <= '0;
    end else begin
      btn_q   <= btn_i;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      rrPtr_q <= rrPtr_d;
      evtId_q <= evtId_d;
    end
  end

  assign evt_valid_o = (state_q == s_offer);
  assign evt_id_o    = evtId_q;
  assign pend_o      = pend_q;
  assign ovf_o       = ovf_q;

`ifdef TAP_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] tsCnt_q;
  logic [TS_WIDTH-1:0] ts_q [N_BTN];
  logic [TS_WIDTH-1:0] evtTs_q;
  logic [N_BTN-1:0]    capVec;

  assign capVec = edgeVec & (~pend_q | clrVec);

  // Tick counter, per-channel capture on new requests, copy out at grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tsCnt_q <= '0;
      evtTs_q <= '0;
      for (int k = 0; k < N_BTN; k++) begin
        ts_q[k] <= '0;
      end
    end else begin
      if (tp) begin
        tsCnt_q <= tsCnt_q + TS_WIDTH'(1);
      end
      for (int k = 0; k < N_BTN; k++) begin
        if (capVec[k]) begin
          ts_q[k] <= tsCnt_q;
        end
      end
      if (grantNow) begin
        evtTs_q <= ts_q[grantIdx];
      end
    end
  end

  assign evt_ts_o = evtTs_q;
`endif

endmodule

// File: tb/tb_tap_event_arbiter.sv
// Directed bench for tap_event_arbiter (default parameters, DIV = 102).
// The timestamp section is compiled in when TAP_TIMESTAMP_EN is defined.
module tb_tap_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic       ready = 1'b0;
  logic       tp;
  logic       evtValid;
  logic [1:0] evtId;
  logic [3:0] pend;
  logic       ovf;
`ifdef TAP_TIMESTAMP_EN
  logic [3:0] evtTs;
`endif

  int testCount = 0;
  int failCount = 0;

  tap_event_arbiter #(
    .N_BTN        (4),
    .CLK_PER_NS   (40),
    .PULSE_PER_NS (4096),
    .TS_WIDTH     (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tp_o        (tp),
    .btn_i       (btn),
    .evt_valid_o (evtValid),
    .evt_ready_i (ready),
    .evt_id_o    (evtId),
`ifdef TAP_TIMESTAMP_EN
    .evt_ts_o    (evtTs),
`endif
    .pend_o      (pend),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic r);
    btn   = b;
    ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in the first cycle after reset release (cycle 0).
  task automatic resetDut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits a bounded number of cycles for an offer, checks its id, then
  // moves one cycle on (the handshake cycle when ready is high).
  task automatic expectGrant(input string tag, input logic [1:0] id);
    int n = 0;
    while (!evtValid && n < 10) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(evtValid), 32'd1);
    checkOutput({tag, "_id"}, 32'(evtId), 32'(id));
    tick();
  endtask

  initial begin
    // Reset values
    applyStimulus(4'b0000, 1'b1);
    resetDut();
    checkOutput("rst_tp", 32'(tp), 32'd0);
    checkOutput("rst_valid", 32'(evtValid), 32'd0);
    checkOutput("rst_id", 32'(evtId), 32'd0);
    checkOutput("rst_pend", 32'(pend), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);

    // Prescaler: pulses at cycles 102, 204, 306
    for (int c = 1; c <= 306; c++) begin
      tick();
      if (c == 101 || c == 102 || c == 103 || c == 204 || c == 306) begin
        checkOutput($sformatf("tp_c%0d", c), 32'(tp), 32'((c % 102) == 0));
      end
    end

    // Single tap on channel 2
    applyStimulus(4'b0100, 1'b1);
    tick();
    checkOutput("tap_pend", 32'(pend), 32'h4);
    checkOutput("tap_valid_early", 32'(evtValid), 32'd0);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("tap_valid", 32'(evtValid), 32'd1);
    checkOutput("tap_id", 32'(evtId), 32'd2);
    checkOutput("tap_pend_clr", 32'(pend), 32'h0);
    tick();
    checkOutput("tap_valid_drop", 32'(evtValid), 32'd0);

    // Round robin: 0,1,3 together from a fresh pointer
    resetDut();
    applyStimulus(4'b1011, 1'b1);
    tick();
    checkOutput("rr_pend", 32'(pend), 32'hB);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("rr_g0_valid", 32'(evtValid), 32'd1);
    checkOutput("rr_g0_id", 32'(evtId), 32'd0);
    checkOutput("rr_g0_pend", 32'(pend), 32'hA);
    tick();
    checkOutput("rr_gap0", 32'(evtValid), 32'd0);
    tick();
    checkOutput("rr_g1_id", 32'(evtId), 32'd1);
    checkOutput("rr_g1_pend", 32'(pend), 32'h8);
    tick();
    checkOutput("rr_gap1", 32'(evtValid), 32'd0);
    tick();
    checkOutput("rr_g3_valid", 32'(evtValid), 32'd1);
    checkOutput("rr_g3_id", 32'(evtId), 32'd3);
    checkOutput("rr_g3_pend", 32'(pend), 32'h0);
    tick();
    // Pointer back at 0: pair 0,1 then pointer at 2: pair 0,3 gives 3 first
    applyStimulus(4'b0011, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b1);
    expectGrant("rr_p01_a", 2'd0);
    expectGrant("rr_p01_b", 2'd1);
    applyStimulus(4'b1001, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b1);
    expectGrant("rr_p03_a", 2'd3);
    expectGrant("rr_p03_b", 2'd0);

    // Backpressure and overflow (pointer now 1)
    applyStimulus(4'b0010, 1'b0);
    tick();
    checkOutput("bp_pend1", 32'(pend), 32'h2);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("bp_offer_id", 32'(evtId), 32'd1);
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkOutput("bp_pend2", 32'(pend), 32'h4);
    checkOutput("bp_ovf_none", 32'(ovf), 32'd0);
    applyStimulus(4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkOutput("bp_ovf_pulse", 32'(ovf), 32'd1);
    checkOutput("bp_ovf_pend", 32'(pend), 32'h4);
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("bp_ovf_end", 32'(ovf), 32'd0);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("bp_hold_valid%0d", i), 32'(evtValid), 32'd1);
      checkOutput($sformatf("bp_hold_id%0d", i), 32'(evtId), 32'd1);
      tick();
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("bp_after_hs", 32'(evtValid), 32'd0);
    tick();
    checkOutput("bp_next_valid", 32'(evtValid), 32'd1);
    checkOutput("bp_next_id", 32'(evtId), 32'd2);
    tick();

    // Same-cycle grant clear plus new edge on channel 3 (pointer now 3)
    applyStimulus(4'b0001, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("sc_offer0", 32'(evtId), 32'd0);
    applyStimulus(4'b1000, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b0);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("sc_grant_cycle", 32'(evtValid), 32'd0);
    applyStimulus(4'b1000, 1'b1);
    tick();
    checkOutput("sc_pend_kept", 32'(pend), 32'h8);
    checkOutput("sc_id3", 32'(evtId), 32'd3);
    checkOutput("sc_no_ovf", 32'(ovf), 32'd0);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("sc_gap", 32'(evtValid), 32'd0);
    tick();
    checkOutput("sc_again_valid", 32'(evtValid), 32'd1);
    checkOutput("sc_again_id", 32'(evtId), 32'd3);
    checkOutput("sc_again_pend", 32'(pend), 32'h0);
    tick();

    // Reset mid-offer, buttons held high across reset release
    applyStimulus(4'b0110, 1'b0);
    tick();
    tick();
    checkOutput("mr_offer", 32'(evtValid), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("mr_valid", 32'(evtValid), 32'd0);
    checkOutput("mr_pend", 32'(pend), 32'h0);
    checkOutput("mr_id", 32'(evtId), 32'd0);
    tick();
    rst = 1'b0;
    checkOutput("mr_rel_pend", 32'(pend), 32'h0);
    tick();
    checkOutput("mr_held_pend", 32'(pend), 32'h6);
    applyStimulus(4'b0110, 1'b1);
    expectGrant("mr_g1", 2'd1);
    expectGrant("mr_g2", 2'd2);
    tick();
    checkOutput("mr_once", 32'(pend), 32'h0);

`ifdef TAP_TIMESTAMP_EN
    // Timestamps with a 4-bit tick counter: 15 then wrap to 0
    begin
      int tpSeen = 0;
      int guard  = 0;
      applyStimulus(4'b0000, 1'b1);
      resetDut();
      while (tpSeen < 15 && guard < 3000) begin
        tick();
        guard++;
        if (tp) tpSeen++;
      end
      checkOutput("ts_tick15_reached", 32'(tpSeen), 32'd15);
      tick();
      applyStimulus(4'b0001, 1'b1);
      tick();
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkOutput("ts_a_id", 32'(evtId), 32'd0);
      checkOutput("ts_a_ts", 32'(evtTs), 32'd15);
      guard = 0;
      while (!tp && guard < 300) begin
        tick();
        guard++;
      end
      checkOutput("ts_tick16_reached", 32'(tp), 32'd1);
      tick();
      applyStimulus(4'b0010, 1'b1);
      tick();
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkOutput("ts_b_id", 32'(evtId), 32'd1);
      checkOutput("ts_b_ts", 32'(evtTs), 32'd0);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/tap_event_arbiter.md
# tap_event_arbiter

Front-end controller for the TapTempo button path. It generates the shared `tp` timepulse tick that drives every button debouncer, and collects the debounced button levels. Each rising edge becomes a one-event request, and the requests are arbitrated round-robin onto a single valid/ready event stream consumed by the tempo computation logic.

## Interface
Parameters:
- `N_BTN`, 4: number of debounced button channels; must be at least 2.
- `CLK_PER_NS`, 40: clock period in ns.
- `PULSE_PER_NS`, 4096: tick period in ns. `DIV = PULSE_PER_NS/CLK_PER_NS` (integer division) must be at least 2.
- `TS_WIDTH`, 16: timestamp width. Used only with `TAP_TIMESTAMP_EN`.

Ports:
- `clk_i` in 1: single system clock.
- `rst_i` in 1: reset, **synchronous, active-high**.
- `tp_o` out 1: timepulse tick, one cycle high every `DIV` cycles; feeds the debouncers' `tp_i`.
- `btn_i` in `N_BTN`: debounced button levels.
- `evt_valid_o` out 1: event offered.
- `evt_ready_i` in 1: consumer accepts.
- `evt_id_o` out `max(1,$clog2(N_BTN))`: channel index of the offered event.
- `evt_ts_o` out `TS_WIDTH`: tick timestamp of the event. Present only with `TAP_TIMESTAMP_EN`.
- `pend_o` out `N_BTN`: pending-request vector.
- `ovf_o` out 1: one-cycle pulse when an edge hits an already-pending channel.

## Operation
- **Prescaler**
  - `pcnt` counts 0..`DIV`-1 and wraps.
  - `tp_o = (pcnt == DIV-1)`, registered.
- **Edge detection**
  - `btn_q <= btn_i` every cycle.
  - `edge = btn_i & ~btn_q`.
  - `btn_q` resets to 0, so a button held high across reset release yields exactly one event.
- **Pending register**
  - An edge on channel k sets `pend[k]`.
  - A grant clears `pend[k]`.
  - An edge arriving the same cycle as the grant clear of the same channel wins: `pend[k]` stays 1, and that counts as a new event.
  - An edge on a channel that is already pending (and not being cleared) leaves `pend[k]=1` and pulses `ovf_o` once per such cycle. The OR of all channels drives a single `ovf_o` pulse.
- **FSM `s_idle` / `s_offer`**
  - In `s_idle`, if `|pend`: choose the first set bit searching from `rr_ptr` upward, modulo `N_BTN`. Load `evt_id_o` (and the timestamp), clear that pend bit, go to `s_offer`.
  - In `s_offer`: `evt_valid_o=1`. `evt_id_o` and `evt_ts_o` are held stable until `evt_ready_i`.
  - On `evt_valid_o & evt_ready_i`: go to `s_idle`, and set `rr_ptr <= (granted+1) mod N_BTN`.
  - `evt_valid_o` never drops without a handshake.
  - `evt_ready_i` is ignored in `s_idle`.
- **Throughput:** at most one event per 2 cycles.

## Timing
- Reset values:
  - `pcnt=0`, `tp_o=0`
  - `btn_q=0`, `pend_o=0`, `ovf_o=0`
  - `evt_valid_o=0`, `evt_id_o=0`, `evt_ts_o=0`
  - `rr_ptr=0`, `ts_cnt=0`, state `s_idle`
- First `tp_o` pulse appears `DIV` cycles after reset deassertion, i.e. in the cycle where `pcnt` reaches `DIV-1`.
- Edge visible on `btn_i` in cycle t:
  - `pend_o[k]=1` in t+1.
  - `evt_valid_o=1` in t+2, when `s_idle` and k is selected.
  - `pend_o[k]` returns to 0 in t+2.
- Handshake in cycle u: `evt_valid_o=0` in u+1. The next grant's `evt_valid_o` rises in u+2 at the earliest.
- Reset asserted mid-offer drops the event and all pending requests; no partial state survives.

## Configuration
- Macro **`TAP_TIMESTAMP_EN`**
- **Defined:**
  - Free-running `ts_cnt` (`TS_WIDTH` bits) increments on each `tp_o` cycle and wraps from 2^`TS_WIDTH`-1 to 0.
  - Per-channel `ts[k]` captures `ts_cnt` when `pend[k]` goes 0→1. A same-cycle grant clear plus new edge also counts as a capture.
  - An overflow edge does not overwrite `ts[k]`; the oldest timestamp is kept.
  - `ts[k]` is copied to `evt_ts_o` at grant.
- **Undefined:**
  - No `evt_ts_o` port and no timestamp registers.
  - All other behaviour is identical.

## Structure
- Package `tap_pkg` holds:
  - the state enum (`s_idle`, `s_offer`)
  - a `DIV` computation function
  - the id-width helper
- Sub-module `tick_prescaler` produces `tp_o`.
- Arbiter, edge detection and timestamps stay in the top.

## Test plan
- **Prescaler:** `CLK_PER_NS=40`, `PULSE_PER_NS=4096` → `DIV=102`. `tp_o` pulses at cycles 102, 204, 306 after reset release, one cycle wide.
- **Single tap:** `btn_i[2]` rises at cycle 10, `evt_ready_i=1` → `pend_o=4'b0100` at 11, `evt_valid_o=1` with id 2 at 12, `evt_valid_o=0` at 13.
- **Round-robin:** channels 0, 1 and 3 rise together, `evt_ready_i=1` → grants in order 0, 1, 3 at 2-cycle spacing. A subsequent channel-0 and channel-3 pair is granted 3 then 0 (`rr_ptr=2` after granting 1, so 3 is found first from 2).
- **Backpressure and overflow:**
  - Hold `evt_ready_i=0` for 20 cycles. `evt_id_o` stays stable.
  - A second edge on a pending channel → `ovf_o` pulses one cycle and `pend_o` is unchanged.
- **Same-cycle clear plus edge:** edge on k in the grant cycle of k → `pend_o[k]` stays 1 and k is granted again after the handshake.
- **`TAP_TIMESTAMP_EN`, `TS_WIDTH=4`:** edges at tick counts 15 and 16 → `evt_ts_o` = 15 then 0 (wrap). Reset mid-offer → `evt_valid_o=0` and `pend_o=0` the next cycle.
